// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: FSM encodings,
// read-select encodings and the default settle latency.
package mult_hilo_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned LATENCY_DEF    = 4;
  localparam int unsigned CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic SEL_HI = 1'b1;
  localparam logic SEL_LO = 1'b0;

  // Counter preload: RUN lasts LATENCY cycles, the last one with the counter at zero.
  function automatic logic [CNT_WIDTH-1:0] latency_load(input int unsigned lat);
    return CNT_WIDTH'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/mult_hilo_unit_hilo_regpair.sv
// Architectural HI/LO register pair: product commit port with priority over
// the independent mthi/mtlo write strobes, plus the mfhi/mflo read mux.
module hilo_regpair
  import mult_hilo_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hi_we,
  input  logic                    lo_we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    commit,
  input  logic [2*DATA_WIDTH-1:0] commit_data,
  input  logic                    rd_sel,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo
);

  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;

  // HI/LO storage: commit overrides any same-cycle register write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit) begin
      hi_r <= commit_data[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_r <= commit_data[DATA_WIDTH-1:0];
    end else begin
      if (hi_we) begin
        hi_r <= wdata;
      end
      if (lo_we) begin
        lo_r <= wdata;
      end
    end
  end

  // Read mux for mfhi/mflo
  always_comb begin
    rd_data = lo_r;
    if (rd_sel == SEL_HI) begin
      rd_data = hi_r;
    end else begin
      rd_data = lo_r;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/mult_hilo_unit.sv
// Sequencer around an external 32x32 multiplier: latches operands, waits the
// settle latency, commits the product into HI/LO and arbitrates mfhi/mthi traffic.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [DATA_WIDTH-1:0] OP_A,
  input  logic [DATA_WIDTH-1:0] OP_B,
  output logic [DATA_WIDTH-1:0] MCND,
  output logic [DATA_WIDTH-1:0] MPLR,
  output logic                  SIGN_SEL,
  input  logic [DATA_WIDTH-1:0] PROD_HI,
  input  logic [DATA_WIDTH-1:0] PROD_LO,
  input  logic                  HI_WE,
  input  logic                  LO_WE,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  RD_REQ,
  input  logic                  RD_SEL,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  STALL
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = latency_load(LATENCY);

  state_e                state_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [DATA_WIDTH-1:0] mcnd_r;
  logic [DATA_WIDTH-1:0] mplr_r;
  logic                  sign_sel_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  run_s;
  logic                  accept_s;
  logic                  commit_s;
  logic                  hi_wr_s;
  logic                  lo_wr_s;
  logic                  stall_s;
  logic [DATA_WIDTH-1:0] hi_s;
  logic [DATA_WIDTH-1:0] lo_s;

  // Request arbitration: an accepted START or an in-flight multiply blocks register traffic
  always_comb begin
    run_s    = 1'b0;
    accept_s = 1'b0;
    commit_s = 1'b0;
    hi_wr_s  = 1'b0;
    lo_wr_s  = 1'b0;
    stall_s  = 1'b0;
    if (state_r == ST_RUN) begin
      run_s    = 1'b1;
      commit_s = (cnt_r == {CNT_WIDTH{1'b0}});
      stall_s  = START | HI_WE | LO_WE | RD_REQ;
    end else begin
      accept_s = START;
      hi_wr_s  = HI_WE & ~START;
      lo_wr_s  = LO_WE & ~START;
      stall_s  = START & (HI_WE | LO_WE);
    end
  end

  // Sequencer FSM with operand latches and registered status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_WIDTH{1'b0}};
      mcnd_r     <= '0;
      mplr_r     <= '0;
      sign_sel_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            mcnd_r     <= OP_A;
            mplr_r     <= OP_B;
            sign_sel_r <= SIGNED;
            cnt_r      <= CNT_LOAD;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (commit_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= {CNT_WIDTH{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  hilo_regpair #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hilo (
    .clk         (CLK),
    .rst         (RST),
    .hi_we       (hi_wr_s),
    .lo_we       (lo_wr_s),
    .wdata       (WDATA),
    .commit      (commit_s),
    .commit_data ({PROD_HI, PROD_LO}),
    .rd_sel      (RD_SEL),
    .rd_data     (RD_DATA),
    .hi          (hi_s),
    .lo          (lo_s)
  );

  assign MCND     = mcnd_r;
  assign MPLR     = mplr_r;
  assign SIGN_SEL = sign_sel_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign STALL    = stall_s;

endmodule
